// File: rtl/mux2_sel_ctrl.sv
// mux2_sel_ctrl: select sequencer for a downstream 2:1 mux.
// Takes a switch request over valid/ready and waits for a boundary strobe
// from the active source. It then waits out an optional hold-off and
// updates sel. The blank output covers the changeover.
// Optional feature: define MUX2_SEL_TIMEOUT_EN to force the switch when no
// boundary arrives within C_TIMEOUT cycles of entering WAIT_BND.
// Without it, WAIT_BND waits indefinitely and timeout is tied low.

module mux2_sel_ctrl #(
    parameter int unsigned C_INIT_SEL = 0,
    parameter int unsigned C_HOLDOFF  = 4,
    parameter int unsigned C_CNT_W    = 8,
    parameter int unsigned C_TIMEOUT  = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic bnd,
    output logic sel,
    output logic busy,
    output logic blank,
    output logic done,
    output logic timeout
);

    localparam logic [C_CNT_W-1:0] HOLD_LOAD =
        C_CNT_W'((C_HOLDOFF == 0) ? 0 : C_HOLDOFF - 1);

    // Reject parameter sets the counters cannot represent
    if (C_INIT_SEL > 1 || C_HOLDOFF > 255 || C_TIMEOUT == 0 ||
        (C_CNT_W < 32 && C_HOLDOFF >= (64'd1 << C_CNT_W))) begin : g_bad_param
        $error("mux2_sel_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BND = 2'd1,
        HOLDOFF  = 2'd2,
        SWITCH   = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [C_CNT_W-1:0]   cnt, cnt_n;
    logic                 target, target_n;
    logic                 sel_n, busy_n, blank_n, done_n;
    logic                 to_hit;
    logic                 bnd_hit;
    logic                 bnd_seen;

    // Boundary (or forced boundary) sampled while waiting for one
    assign bnd_hit   = (state == WAIT_BND) && (bnd || to_hit);
    assign req_ready = (state == IDLE);

`ifdef MUX2_SEL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(C_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(C_TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_seen;
    logic            to_flag;

    assign to_hit = (state == WAIT_BND) && (to_cnt == TO_LAST) && !bnd;

    // Wait-time counter (zero outside WAIT_BND) and timeout bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            to_seen <= 1'b0;
            to_flag <= 1'b0;
            timeout <= 1'b0;
        end else begin
            to_cnt  <= (state == WAIT_BND) ? to_cnt + TO_W'(1) : '0;
            to_seen <= to_hit;
            if (state == IDLE)
                to_flag <= 1'b0;
            else if (state == WAIT_BND && bnd_seen)
                to_flag <= to_seen;
            timeout <= (state == SWITCH) && to_flag;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Remember the boundary for one cycle; the FSM acts on it next edge
    always_ff @(posedge clk) begin
        if (rst)
            bnd_seen <= 1'b0;
        else
            bnd_seen <= bnd_hit;
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            target <= 1'(C_INIT_SEL);
            sel    <= 1'(C_INIT_SEL);
            busy   <= 1'b0;
            blank  <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            target <= target_n;
            sel    <= sel_n;
            busy   <= busy_n;
            blank  <= blank_n;
            done   <= done_n;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        target_n = target;
        sel_n    = sel;
        busy_n   = busy;
        blank_n  = blank;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_sel == sel) begin
                        done_n = 1'b1;
                    end else begin
                        target_n = req_sel;
                        busy_n   = 1'b1;
                        state_n  = WAIT_BND;
                    end
                end
            end
            WAIT_BND: begin
                if (bnd_hit)
                    blank_n = 1'b1;
                if (bnd_seen) begin
                    if (C_HOLDOFF == 0) begin
                        state_n = SWITCH;
                    end else begin
                        cnt_n   = HOLD_LOAD;
                        state_n = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                if (cnt == '0)
                    state_n = SWITCH;
                else
                    cnt_n = cnt - C_CNT_W'(1);
            end
            SWITCH: begin
                sel_n   = target;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                blank_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux2_sel_ctrl.sv
// tb_mux2_sel_ctrl: directed bench for mux2_sel_ctrl.
// Instance a: C_INIT_SEL=0, C_HOLDOFF=4.
// Instance b: C_INIT_SEL=1, C_HOLDOFF=0, C_TIMEOUT=16.
// Both instances share clk and rst.

module tb_mux2_sel_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic req_valid_a, req_sel_a, bnd_a;
    logic req_ready_a, sel_a, busy_a, blank_a, done_a, timeout_a;
    logic req_valid_b, req_sel_b, bnd_b;
    logic req_ready_b, sel_b, busy_b, blank_b, done_b, timeout_b;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    mux2_sel_ctrl #(
        .C_INIT_SEL(0), .C_HOLDOFF(4), .C_CNT_W(8), .C_TIMEOUT(1024)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_sel(req_sel_a), .req_ready(req_ready_a),
        .bnd(bnd_a), .sel(sel_a), .busy(busy_a), .blank(blank_a),
        .done(done_a), .timeout(timeout_a)
    );

    mux2_sel_ctrl #(
        .C_INIT_SEL(1), .C_HOLDOFF(0), .C_CNT_W(8), .C_TIMEOUT(16)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_sel(req_sel_b), .req_ready(req_ready_b),
        .bnd(bnd_b), .sel(sel_b), .busy(busy_b), .blank(blank_b),
        .done(done_b), .timeout(timeout_b)
    );

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid_a = 1'b0; req_sel_a = 1'b0; bnd_a = 1'b0;
        req_valid_b = 1'b0; req_sel_b = 1'b0; bnd_b = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state for both instances
        check("a_rst_sel",   32'(sel_a),       32'd0);
        check("a_rst_ready", 32'(req_ready_a), 32'd1);
        check("a_rst_busy",  32'(busy_a),      32'd0);
        check("a_rst_blank", 32'(blank_a),     32'd0);
        check("a_rst_done",  32'(done_a),      32'd0);
        check("a_rst_to",    32'(timeout_a),   32'd0);
        check("b_rst_sel",   32'(sel_b),       32'd1);
        check("b_rst_ready", 32'(req_ready_b), 32'd1);
        check("b_rst_busy",  32'(busy_b),      32'd0);
        check("b_rst_blank", 32'(blank_b),     32'd0);
        check("b_rst_done",  32'(done_b),      32'd0);

        // A: switch 0->1 with a hold-off of 4 cycles
        req_valid_a = 1'b1; req_sel_a = 1'b1;
        tick();
        req_valid_a = 1'b0;
        check("a_acc_busy",  32'(busy_a),      32'd1);
        check("a_acc_ready", 32'(req_ready_a), 32'd0);
        check("a_acc_sel",   32'(sel_a),       32'd0);
        repeat (3) tick();
        check("a_wait_busy",  32'(busy_a),  32'd1);
        check("a_wait_blank", 32'(blank_a), 32'd0);
        check("a_wait_sel",   32'(sel_a),   32'd0);
        bnd_a = 1'b1;
        tick();
        bnd_a = 1'b0;
        check("a_bnd_blank", 32'(blank_a), 32'd1);
        check("a_bnd_sel",   32'(sel_a),   32'd0);
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) bnd_a = 1'b1;
            tick();
            bnd_a = 1'b0;
            check("a_hold_sel",   32'(sel_a),   32'd0);
            check("a_hold_done",  32'(done_a),  32'd0);
            check("a_hold_blank", 32'(blank_a), 32'd1);
        end
        tick();
        check("a_sw_sel",   32'(sel_a),       32'd1);
        check("a_sw_done",  32'(done_a),      32'd1);
        check("a_sw_busy",  32'(busy_a),      32'd0);
        check("a_sw_blank", 32'(blank_a),     32'd0);
        check("a_sw_ready", 32'(req_ready_a), 32'd1);
        tick();
        check("a_post_done", 32'(done_a), 32'd0);
        check("a_post_sel",  32'(sel_a),  32'd1);

        // A: request for the current select completes immediately
        req_valid_a = 1'b1; req_sel_a = 1'b1;
        tick();
        req_valid_a = 1'b0;
        check("a_noop_done", 32'(done_a), 32'd1);
        check("a_noop_busy", 32'(busy_a), 32'd0);
        check("a_noop_sel",  32'(sel_a),  32'd1);
        tick();
        check("a_noop_done_end", 32'(done_a), 32'd0);

        // A: a request held during a switch is taken right after done
        req_valid_a = 1'b1; req_sel_a = 1'b0;
        tick();
        check("a_held_busy",  32'(busy_a),      32'd1);
        check("a_held_ready", 32'(req_ready_a), 32'd0);
        repeat (2) tick();
        check("a_held_ready2", 32'(req_ready_a), 32'd0);
        check("a_held_done0",  32'(done_a),      32'd0);
        bnd_a = 1'b1;
        tick();
        bnd_a = 1'b0;
        repeat (5) tick();
        check("a_held_pre_done",  32'(done_a),      32'd0);
        check("a_held_pre_ready", 32'(req_ready_a), 32'd0);
        tick();
        check("a_first_done",  32'(done_a),      32'd1);
        check("a_first_sel",   32'(sel_a),       32'd0);
        check("a_first_ready", 32'(req_ready_a), 32'd1);
        tick();
        check("a_held_done",   32'(done_a), 32'd1);
        check("a_held_sel",    32'(sel_a),  32'd0);
        check("a_held_busy0",  32'(busy_a), 32'd0);
        req_valid_a = 1'b0;
        tick();
        check("a_held_done_end", 32'(done_a), 32'd0);

        // B: boundary coinciding with acceptance is ignored; zero hold-off
        req_valid_b = 1'b1; req_sel_b = 1'b0; bnd_b = 1'b1;
        tick();
        req_valid_b = 1'b0; bnd_b = 1'b0;
        check("b_acc_busy",  32'(busy_b),  32'd1);
        check("b_acc_blank", 32'(blank_b), 32'd0);
        repeat (3) tick();
        check("b_wait_sel",   32'(sel_b),   32'd1);
        check("b_wait_blank", 32'(blank_b), 32'd0);
        check("b_wait_busy",  32'(busy_b),  32'd1);
        bnd_b = 1'b1;
        tick();
        check("b_bnd_blank", 32'(blank_b), 32'd1);
        check("b_bnd_sel",   32'(sel_b),   32'd1);
        tick();
        check("b_sw_sel0",  32'(sel_b),  32'd1);
        check("b_sw_done0", 32'(done_b), 32'd0);
        tick();
        bnd_b = 1'b0;
        check("b_sw_sel",   32'(sel_b),     32'd0);
        check("b_sw_done",  32'(done_b),    32'd1);
        check("b_sw_blank", 32'(blank_b),   32'd0);
        check("b_sw_busy",  32'(busy_b),    32'd0);
        check("b_sw_to",    32'(timeout_b), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("b_no_extra_done", 32'(done_b), 32'd0);
            check("b_no_extra_sel",  32'(sel_b),  32'd0);
        end

        // A: reset during hold-off drops the request
        req_valid_a = 1'b1; req_sel_a = 1'b1;
        tick();
        req_valid_a = 1'b0;
        bnd_a = 1'b1;
        tick();
        bnd_a = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("a_mrst_sel",   32'(sel_a),       32'd0);
        check("a_mrst_busy",  32'(busy_a),      32'd0);
        check("a_mrst_blank", 32'(blank_a),     32'd0);
        check("a_mrst_done",  32'(done_a),      32'd0);
        check("a_mrst_ready", 32'(req_ready_a), 32'd1);
        check("b_mrst_sel",   32'(sel_b),       32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("a_mrst_nodone", 32'(done_a), 32'd0);
            check("a_mrst_nosel",  32'(sel_a),  32'd0);
        end

        // B: no boundary ever arrives
        req_valid_b = 1'b1; req_sel_b = 1'b0;
        tick();
        req_valid_b = 1'b0;
`ifdef MUX2_SEL_TIMEOUT_EN
        repeat (17) tick();
        check("b_to_pre_sel",   32'(sel_b),   32'd1);
        check("b_to_pre_done",  32'(done_b),  32'd0);
        check("b_to_pre_blank", 32'(blank_b), 32'd1);
        tick();
        check("b_to_sel",  32'(sel_b),     32'd0);
        check("b_to_done", 32'(done_b),    32'd1);
        check("b_to_to",   32'(timeout_b), 32'd1);
        check("b_to_busy", 32'(busy_b),    32'd0);
        tick();
        check("b_to_to_end",   32'(timeout_b), 32'd0);
        check("b_to_done_end", 32'(done_b),    32'd0);
`else
        repeat (100) tick();
        check("b_nto_sel",  32'(sel_b),     32'd1);
        check("b_nto_busy", 32'(busy_b),    32'd1);
        check("b_nto_done", 32'(done_b),    32'd0);
        check("b_nto_to",   32'(timeout_b), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
